// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: base opcodes, immediate formats and the
// XLEN-independent part of a decoded instruction.
package riscv_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  // Immediate and PC are XLEN wide, so they live beside this struct in the stage entry.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       rs1_used;
    logic       rs2_used;
    logic       rd_we;
    logic       illegal;
  } decoded_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field decoder: raw 32-bit instruction to register indices,
// function fields, sign-extended immediate and legality.
module instr_field_decode
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic [31:0]     instr,
  output decoded_t        dec,
  output logic [XLEN-1:0] imm
);

  logic [6:0]         opcode;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic [5:0]         hi6;
  imm_type_e          imm_type;
  logic signed [31:0] imm32;
  logic               has_rd;
  logic               has_rs1;
  logic               has_rs2;
  logic               is_op;
  logic               known;
  logic               bad_fields;

  always_comb begin
    opcode  = instr[6:0];
    f3      = instr[14:12];
    f7      = instr[31:25];
    hi6     = instr[31:26];
    is_op   = (opcode == OP);
    has_rd  = !((opcode == STORE) || (opcode == BRANCH));
    has_rs1 = !((opcode == LUI) || (opcode == AUIPC) || (opcode == JAL));
    has_rs2 = is_op || (opcode == STORE) || (opcode == BRANCH);

    case (opcode)
      OP_IMM, LOAD, JALR, SYSTEM: imm_type = IMM_I;
      STORE:                      imm_type = IMM_S;
      BRANCH:                     imm_type = IMM_B;
      LUI, AUIPC:                 imm_type = IMM_U;
      JAL:                        imm_type = IMM_J;
      default:                    imm_type = IMM_NONE;
    endcase

    case (imm_type)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = XLEN'(imm32);

    known      = 1'b1;
    bad_fields = 1'b0;
    case (opcode)
      LOAD:   bad_fields = (XLEN == 64) ? (f3 == 3'd7)
                                        : ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
      STORE:  bad_fields = (XLEN == 64) ? (f3 > 3'd3) : (f3 > 3'd2);
      BRANCH: bad_fields = (f3 == 3'd2) || (f3 == 3'd3);
      JALR:   bad_fields = (f3 != 3'd0);
      OP: begin
        if (f7 == 7'b0100000)
          bad_fields = !((f3 == 3'd0) || (f3 == 3'd5));
        else
          bad_fields = !((f7 == 7'b0000000) || (SUPPORT_M && (f7 == 7'b0000001)));
      end
      // RV64 shifts use a 6-bit shamt, so only instr[31:26] carries the function code.
      OP_IMM: begin
        if (f3 == 3'd1)
          bad_fields = (XLEN == 64) ? (hi6 != 6'b000000) : (f7 != 7'b0000000);
        else if (f3 == 3'd5)
          bad_fields = (XLEN == 64) ? !((hi6 == 6'b000000) || (hi6 == 6'b010000))
                                    : !((f7 == 7'b0000000) || (f7 == 7'b0100000));
      end
      MISC_MEM, SYSTEM, JAL, LUI, AUIPC: bad_fields = 1'b0;
      default: known = 1'b0;
    endcase

    dec.opcode   = opcode;
    dec.rd       = has_rd  ? instr[11:7]  : 5'd0;
    dec.rs1      = has_rs1 ? instr[19:15] : 5'd0;
    dec.rs2      = has_rs2 ? instr[24:20] : 5'd0;
    dec.funct3   = f3;
    dec.funct7   = is_op ? f7 : 7'd0;
    dec.rs1_used = has_rs1;
    dec.rs2_used = has_rs2;
    dec.rd_we    = has_rd && (instr[11:7] != 5'd0);
    dec.illegal  = (instr[1:0] != 2'b11) || !known || bad_fields;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one decoder on the input side feeding a main/skid
// entry pair so in_ready depends only on registered state and reset.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_rd_we,
  output logic            out_illegal
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    decoded_t        dec;
  } entry_t;

  decoded_t        in_dec;
  logic [XLEN-1:0] in_imm;
  entry_t          new_entry;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  logic            take_in;
  logic            drain;

  instr_field_decode #(
    .XLEN      (XLEN),
    .SUPPORT_M (SUPPORT_M)
  ) u_field_decode (
    .instr (in_instr),
    .dec   (in_dec),
    .imm   (in_imm)
  );

  assign in_ready = !skid_q.valid && !reset;

  always_comb begin
    new_entry.valid = 1'b1;
    new_entry.pc    = in_pc;
    new_entry.imm   = in_imm;
    new_entry.dec   = in_dec;

    take_in = in_valid && in_ready;
    drain   = main_q.valid && out_ready;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else begin
      if (drain)
        main_d.valid = 1'b0;
      // Skid is older than anything arriving now, so it always refills main first.
      if (skid_q.valid && (drain || !main_q.valid)) begin
        main_d       = skid_q;
        skid_d.valid = 1'b0;
      end else if (take_in) begin
        if (!main_q.valid || drain)
          main_d = new_entry;
        else
          skid_d = new_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_valid    = main_q.valid;
  assign out_pc       = main_q.pc;
  assign out_imm      = main_q.imm;
  assign out_opcode   = main_q.dec.opcode;
  assign out_rd       = main_q.dec.rd;
  assign out_rs1      = main_q.dec.rs1;
  assign out_rs2      = main_q.dec.rs2;
  assign out_funct3   = main_q.dec.funct3;
  assign out_funct7   = main_q.dec.funct7;
  assign out_rs1_used = main_q.dec.rs1_used;
  assign out_rs2_used = main_q.dec.rs2_used;
  assign out_rd_we    = main_q.dec.rd_we;
  assign out_illegal  = main_q.dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: an RV32 (no M) and an RV64 (with M) stage driven in lockstep,
// checked against hand-decoded expected fields and handshake behaviour.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, rs1_used_a, rs2_used_a, rd_we_a, illegal_a;
  logic [31:0] out_pc_a, imm_a;
  logic [6:0]  opcode_a, funct7_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [2:0]  funct3_a;

  logic        in_ready_b, out_valid_b, rs1_used_b, rs2_used_b, rd_we_b, illegal_b;
  logic [63:0] out_pc_b, imm_b;
  logic [6:0]  opcode_b, funct7_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [2:0]  funct3_b;

  int total_checks = 0;
  int bad_checks   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SUPPORT_M(1'b0)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a),
    .out_opcode(opcode_a), .out_rd(rd_a), .out_rs1(rs1_a), .out_rs2(rs2_a),
    .out_funct3(funct3_a), .out_funct7(funct7_a), .out_imm(imm_a),
    .out_rs1_used(rs1_used_a), .out_rs2_used(rs2_used_a),
    .out_rd_we(rd_we_a), .out_illegal(illegal_a)
  );

  decode_stage #(.XLEN(64), .SUPPORT_M(1'b1)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_pc({32'd0, in_pc}), .in_instr(in_instr),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
    .out_opcode(opcode_b), .out_rd(rd_b), .out_rs1(rs1_b), .out_rs2(rs2_b),
    .out_funct3(funct3_b), .out_funct7(funct7_b), .out_imm(imm_b),
    .out_rs1_used(rs1_used_b), .out_rs2_used(rs2_used_b),
    .out_rd_we(rd_we_b), .out_illegal(illegal_b)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = valid;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    step();
    step();
    checkOutput("reset_out_valid", 64'(out_valid_a), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready_a), 64'd0);
    checkOutput("reset_out_pc", 64'(out_pc_a), 64'd0);
    checkOutput("reset_out_imm", 64'(imm_a), 64'd0);

    reset = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 64'(in_ready_a), 64'd1);

    // Back-to-back stream with out_ready high: one result per cycle.
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'h00500093, 32'h100);
    step();
    checkOutput("addi_valid", 64'(out_valid_a), 64'd1);
    checkOutput("addi_rd", 64'(rd_a), 64'd1);
    checkOutput("addi_rs1", 64'(rs1_a), 64'd0);
    checkOutput("addi_imm", 64'(imm_a), 64'd5);
    checkOutput("addi_rd_we", 64'(rd_we_a), 64'd1);
    checkOutput("addi_rs2_used", 64'(rs2_used_a), 64'd0);
    checkOutput("addi_illegal", 64'(illegal_a), 64'd0);
    checkOutput("addi_pc", 64'(out_pc_a), 64'h100);
    checkOutput("addi_imm64", imm_b, 64'd5);

    applyStimulus(1'b1, 32'hFE20AE23, 32'h104);
    step();
    checkOutput("sw_valid", 64'(out_valid_a), 64'd1);
    checkOutput("sw_imm", 64'(imm_a), 64'hFFFFFFFC);
    checkOutput("sw_rd", 64'(rd_a), 64'd0);
    checkOutput("sw_rs2", 64'(rs2_a), 64'd2);
    checkOutput("sw_rd_we", 64'(rd_we_a), 64'd0);
    checkOutput("sw_imm64", imm_b, 64'hFFFFFFFFFFFFFFFC);

    applyStimulus(1'b1, 32'hFE000CE3, 32'h108);
    step();
    checkOutput("beq_imm", 64'(imm_a), 64'hFFFFFFF8);
    checkOutput("beq_rs2_used", 64'(rs2_used_a), 64'd1);
    checkOutput("beq_imm64", imm_b, 64'hFFFFFFFFFFFFFFF8);

    applyStimulus(1'b1, 32'h123452B7, 32'h10C);
    step();
    checkOutput("lui_imm", 64'(imm_a), 64'h12345000);
    checkOutput("lui_rs1_used", 64'(rs1_used_a), 64'd0);
    checkOutput("lui_rs1", 64'(rs1_a), 64'd0);
    checkOutput("lui_rd", 64'(rd_a), 64'd5);

    applyStimulus(1'b1, 32'h00000000, 32'h110);
    step();
    checkOutput("zero_illegal", 64'(illegal_a), 64'd1);

    applyStimulus(1'b1, 32'h02208033, 32'h114);
    step();
    checkOutput("mul_illegal_noM", 64'(illegal_a), 64'd1);
    checkOutput("mul_illegal_M", 64'(illegal_b), 64'd0);
    checkOutput("mul_funct7", 64'(funct7_a), 64'h01);
    checkOutput("mul_rd_we", 64'(rd_we_a), 64'd0);

    // slli by 32: illegal shamt on RV32, legal on RV64.
    applyStimulus(1'b1, 32'h02009093, 32'h118);
    step();
    checkOutput("slli32_illegal_rv32", 64'(illegal_a), 64'd1);
    checkOutput("slli32_illegal_rv64", 64'(illegal_b), 64'd0);
    checkOutput("slli32_pc", 64'(out_pc_a), 64'h118);

    applyStimulus(1'b0, 32'h0, 32'h0);
    step();
    checkOutput("idle_out_valid", 64'(out_valid_a), 64'd0);

    // Backpressure: two absorbed, third held off, then drained in order.
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00100093, 32'h200);
    step();
    checkOutput("bp_ready_after_1", 64'(in_ready_a), 64'd1);
    applyStimulus(1'b1, 32'h00200113, 32'h204);
    step();
    checkOutput("bp_ready_after_2", 64'(in_ready_a), 64'd0);
    checkOutput("bp_head_pc", 64'(out_pc_a), 64'h200);
    applyStimulus(1'b1, 32'h00300193, 32'h208);
    step();
    checkOutput("bp_stall_pc", 64'(out_pc_a), 64'h200);
    checkOutput("bp_stall_imm", 64'(imm_a), 64'd1);
    checkOutput("bp_stall_ready", 64'(in_ready_a), 64'd0);
    out_ready = 1'b1;
    step();
    checkOutput("bp_rel1_pc", 64'(out_pc_a), 64'h204);
    checkOutput("bp_rel1_imm", 64'(imm_a), 64'd2);
    checkOutput("bp_rel1_ready", 64'(in_ready_a), 64'd1);
    step();
    checkOutput("bp_rel2_pc", 64'(out_pc_a), 64'h208);
    checkOutput("bp_rel2_imm", 64'(imm_a), 64'd3);
    checkOutput("bp_rel2_valid", 64'(out_valid_a), 64'd1);
    applyStimulus(1'b0, 32'h0, 32'h0);
    step();
    checkOutput("bp_drained", 64'(out_valid_a), 64'd0);

    // Flush with both entries full and a new word presented.
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00400093, 32'h300);
    step();
    applyStimulus(1'b1, 32'h00500093, 32'h304);
    step();
    applyStimulus(1'b1, 32'h00600093, 32'h308);
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("flush_full_valid", 64'(out_valid_a), 64'd0);
    checkOutput("flush_full_ready", 64'(in_ready_a), 64'd1);
    out_ready = 1'b1;
    step();
    checkOutput("flush_full_nothing", 64'(out_valid_a), 64'd0);

    // Flush while in_ready is high: the presented word is dropped.
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00700093, 32'h310);
    step();
    applyStimulus(1'b1, 32'h00800093, 32'h314);
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("flush_drop_valid", 64'(out_valid_a), 64'd0);
    step();
    checkOutput("flush_drop_nothing", 64'(out_valid_a), 64'd0);

    // Reset while holding a word.
    applyStimulus(1'b1, 32'h00900093, 32'h400);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("rst_mid_pre_valid", 64'(out_valid_a), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_ready_low", 64'(in_ready_a), 64'd0);
    step();
    checkOutput("rst_mid_valid", 64'(out_valid_a), 64'd0);
    checkOutput("rst_mid_ready", 64'(in_ready_a), 64'd0);
    checkOutput("rst_mid_pc", 64'(out_pc_a), 64'd0);
    checkOutput("rst_mid_imm", 64'(imm_a), 64'd0);
    checkOutput("rst_mid_rd", 64'(rd_a), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_ready_after", 64'(in_ready_a), 64'd1);
    step();
    checkOutput("rst_mid_stays_empty", 64'(out_valid_a), 64'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
